round_robin_mux_arbiter: RTL

//   Shares one WIDTH-bit output channel among N_REQ requesters, each with a

---
 rtl/round_robin_mux_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/round_robin_mux_arbiter.sv
// Purpose : round-robin N_REQ:1 mux arbiter feeding a single registered output slot.
// Latency : 1 cycle from an accepted request (req_valid & req_ready) to out_valid with that word.
// Backpr. : req_ready is withheld while the slot is full and out_ready is low; a full slot
//           that is being drained can be reloaded on the same cycle (1 word/cycle).
//
// Ports
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset
//   req_valid  per-requester offer
//   req_data   requester i word at [i*WIDTH +: WIDTH]
//   req_ready  one-hot (or zero) accept strobe towards the requesters
//   out_valid  slot holds a word
//   out_data   slot word
//   out_src    index of the requester that supplied out_data
//   out_ready  consumer takes the slot word this cycle
module round_robin_mux_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(N_REQ)-1:0] out_src,
    input  logic                     out_ready
);

    localparam int                 PTR_W    = $clog2(N_REQ);
    localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]   ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e         state_q, state_d;

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [PTR_W-1:0]    out_src_q,  out_src_d;
    logic [PTR_W-1:0]    ptr_q,      ptr_d;

    logic                can_load;
    logic                gnt_any;
    logic [PTR_W-1:0]    gnt_idx;
    logic [PTR_W-1:0]    cand_idx;
    logic                transfer;

    // ------------------------------------------------------------------
    // Round-robin grant.
    // Walk the priority order from the lowest priority (ptr-1) up to the
    // highest (ptr); the last valid candidate seen is therefore the one with
    // the highest priority. ptr never exceeds N_REQ-1, so the modulo keeps
    // the candidate in range for non power-of-two N_REQ as well.
    // ------------------------------------------------------------------
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (req_valid[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Slot FSM: next state
    // A full slot that is drained and reloaded in the same cycle stays FULL.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (transfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready && !transfer) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Slot FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q == FULL);
        can_load  = (state_q == EMPTY) || out_ready;
    end

    // Accept strobe: suppressed during reset so nothing is consumed from
    // a requester on a cycle whose load is about to be discarded.
    always_comb begin
        req_ready = '0;
        if (!rst && can_load && gnt_any) begin
            req_ready = ONE_HOT0 << gnt_idx;
        end
    end

    assign transfer = |(req_valid & req_ready);

    // ------------------------------------------------------------------
    // Datapath next state: load the granted word, otherwise hold.
    // The pointer moves only on a transfer, to the requester just after
    // the winner, so the winner becomes the lowest priority next time.
    // ------------------------------------------------------------------
    always_comb begin
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        ptr_d      = ptr_q;
        if (transfer) begin
            out_data_d = req_data[gnt_idx*WIDTH +: WIDTH];
            out_src_d  = gnt_idx;
            ptr_d      = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            out_src_q  <= '0;
            ptr_q      <= '0;
        end else begin
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_data = out_data_q;
    assign out_src  = out_src_q;

endmodule
